draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the random source.
REQ-002 Parameter MAX_VAL, default 10: largest legal draw value, inclusive.
REQ-003 Parameter WAIT_CYCLES, default 3, legal range 1..15: settle cycles between grant and sample.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester draw request; level, held until ack.
REQ-007 rnd_in  input  4  free-running value from the random number generator.
REQ-008 grant  output  NUM_REQ  one-hot owner of the current draw; all-zero when idle.
REQ-009 ack  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-010 draw_value  output  4  last captured draw; holds between draws.
REQ-011 draw_valid  output  1  one-cycle pulse, coincident with ack.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE, ACK.
REQ-014 IDLE: if any req bit is high, the FSM SHALL select a winner round-robin, starting at the index after last_grant and wrapping at NUM_REQ-1 -> 0.
REQ-015 On leaving IDLE, grant SHALL be one-hot on the winner, the settle counter SHALL load WAIT_CYCLES-1, and the next state SHALL be SETTLE.
REQ-016 SETTLE: the counter SHALL decrement each cycle; on the edge where it reads 0, the FSM SHALL go to SAMPLE (exactly WAIT_CYCLES cycles in SETTLE).
REQ-017 SAMPLE: if rnd_in <= MAX_VAL, rnd_in SHALL be captured into draw_value and the FSM SHALL go to ACK; otherwise the FSM SHALL stay in SAMPLE and retry next cycle (unsigned 4-bit compare).
REQ-018 ACK: ack[winner] and draw_valid SHALL be high for exactly this one cycle; last_grant SHALL update to the winner; grant SHALL clear; the next state SHALL be IDLE.
REQ-019 Latency: for req sampled at edge k with in-range rnd_in, ack SHALL be high in the cycle after edge k+WAIT_CYCLES+1.
REQ-020 Abort: if req[winner] drops during SETTLE or SAMPLE, the FSM SHALL return to IDLE next edge with no ack, draw_value unchanged, and last_grant unchanged.
REQ-021 Requests from other requesters during a draw SHALL be ignored until IDLE; grants SHALL never overlap.
REQ-022 A requester still asserting req in the cycle after its ack SHALL be treated as a new request and SHALL lose priority to any other pending requester.
REQ-023 With no requests, the FSM SHALL stay in IDLE with grant, ack and draw_valid low.

Reset
REQ-024 reset_n low SHALL immediately force IDLE and set grant=0, ack=0, draw_valid=0, draw_value=0, busy=0, counter=0, last_grant=NUM_REQ-1 (requester 0 first), including mid-draw.
REQ-025 Deassertion SHALL take effect at the first rising clk edge with reset_n high; there SHALL be no ack for a draw cut by reset.

Structure
REQ-026 The shared package SHALL hold the FSM state enum, default MAX_VAL, default WAIT_CYCLES and the 4-bit draw-width constant.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter: inputs req and last_grant, output one-hot winner, purely combinational.
REQ-028 draw_arbiter SHALL instantiate rr_arbiter once and contain the FSM, settle counter, capture register and last_grant register.

Verification
REQ-029 Single request: req=0001, rnd_in=7, WAIT_CYCLES=3 -> grant=0001 after one edge, ack=0001, draw_valid=1 and draw_value=7 in the cycle after edge k+4, then IDLE.
REQ-030 Fairness: req=1111 held, acks re-requested -> service order 0,1,2,3,0; no requester served twice before the others.
REQ-031 Out of range: rnd_in=12,13 then 5 in SAMPLE -> two retry cycles, then draw_value=5, single ack.
REQ-032 Abort: req[2] dropped in SETTLE -> no ack, draw_value unchanged, next req=0110 grants 1 (pointer not advanced).
REQ-033 Reset mid-SAMPLE: reset_n low -> grant=0, busy=0, draw_value=0 immediately; after release, req=1000 with req=0001 pending grants 0 first.
REQ-034 Boundary: rnd_in=10 with MAX_VAL=10 -> accepted first cycle; rnd_in=11 -> retried.

Source files
------------

// File: rtl/draw_arbiter_pkg.sv
// Shared constants and FSM state encoding for the draw arbiter.
// Draw values and the settle counter are both 4 bits wide.
package draw_arbiter_pkg;

  localparam int DRAW_W          = 4;
  localparam int CNT_W           = 4;
  localparam int DEF_MAX_VAL     = 10;
  localparam int DEF_WAIT_CYCLES = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE,
    ACK    = ST_ACK
  } state_e;

endpackage

// File: rtl/draw_arbiter_rr.sv
// Round-robin pick: the first requester after last_grant (wrapping) wins.
// Purely combinational, one-hot or all-zero winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] winner
);

  logic found;

  // Scan offsets 1..NUM_REQ from the last owner; last owner itself is checked last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == ((int'(last_grant) + k) % NUM_REQ))) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Shares one random source among NUM_REQ requesters: grant, settle, sample, ack.
// Ack arrives WAIT_CYCLES+2 cycles after request; out-of-range samples stall in SAMPLE.
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_VAL     = DEF_MAX_VAL,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DRAW_W-1:0]  rnd_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] ack,
  output logic [DRAW_W-1:0]  draw_value,
  output logic               draw_valid,
  output logic               busy
);

  localparam int                IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DRAW_W-1:0] MAX_V       = DRAW_W'(MAX_VAL);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_RST    = IDX_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                draw_valid_q, draw_valid_d;
  logic [DRAW_W-1:0]   draw_value_q, draw_value_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0]  winner;
  logic [IDX_W-1:0]    owner_idx;
  logic                owner_alive;
  logic                rnd_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_idx = IDX_W'(i);
    end
  end

  assign owner_alive = |(req & grant_q);
  assign rnd_ok      = (rnd_in <= MAX_V);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack_d        = '0;
    draw_valid_d = 1'b0;
    draw_value_d = draw_value_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SETTLE;
          grant_d = winner;
          cnt_d   = SETTLE_LOAD;
        end
      end

      SETTLE: begin
        // A dropped request abandons the draw without touching the priority pointer.
        if (!owner_alive) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SAMPLE: begin
        if (!owner_alive) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (rnd_ok) begin
          state_d      = ACK;
          draw_value_d = rnd_in;
          ack_d        = grant_q;
          draw_valid_d = 1'b1;
          grant_d      = '0;
          last_grant_d = owner_idx;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      draw_valid_q <= 1'b0;
      draw_value_q <= '0;
      cnt_q        <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      draw_valid_q <= draw_valid_d;
      draw_value_q <= draw_value_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign draw_valid = draw_valid_q;
  assign draw_value = draw_value_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed and random stimulus for draw_arbiter against a transaction-level reference.
module tb_draw_arbiter;

  localparam int NR   = 4;
  localparam int W    = 3;
  localparam int MAXV = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NR-1:0] req = '0;
  logic [3:0]    rnd_in = '0;
  logic [NR-1:0] grant, ack;
  logic [3:0]    draw_value;
  logic          draw_valid, busy;

  int n_chk = 0;
  int n_err = 0;

  // Reference: who owns the source, how long it has waited, and the last result.
  int m_owner, m_elapsed, m_last, m_value, m_ack_who;
  bit m_ack;

  draw_arbiter #(.NUM_REQ(NR), .MAX_VAL(MAXV), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rnd_in(rnd_in),
    .grant(grant), .ack(ack), .draw_value(draw_value),
    .draw_valid(draw_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_owner = -1; m_elapsed = 0; m_last = NR - 1; m_value = 0; m_ack = 0; m_ack_who = -1;
  endfunction

  function automatic void model_step();
    bit found;
    if (!reset_n) begin
      m_reset();
      return;
    end
    if (m_ack) begin
      m_ack = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (!found && req[c]) begin
          m_owner = c; m_elapsed = 0; found = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (m_elapsed < W) begin
      m_elapsed++;
    end else if (int'(rnd_in) <= MAXV) begin
      m_value = int'(rnd_in); m_last = m_owner; m_ack_who = m_owner;
      m_ack = 1; m_owner = -1;
    end
  endfunction

  task automatic compare_all();
    chk("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("ack", 32'(ack), m_ack ? (32'd1 << m_ack_who) : 32'd0);
    chk("draw_valid", 32'(draw_valid), 32'(m_ack));
    chk("draw_value", 32'(draw_value), 32'(m_value));
    chk("busy", 32'(busy), 32'((m_owner >= 0) || m_ack));
  endtask

  task automatic step(input logic [NR-1:0] r, input logic [3:0] v);
    req = r; rnd_in = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_until_ack(input logic [NR-1:0] r, input logic [3:0] v,
                               output int n, output int who);
    n = 0; who = -1;
    for (int c = 0; c < 50 && who < 0; c++) begin
      step(r, v);
      n++;
      for (int i = 0; i < NR; i++) if (ack[i]) who = i;
    end
    if (who < 0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic arst();
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_value", 32'(draw_value), 32'd0);
    compare_all();
    step('0, 4'd0);
    step('0, 4'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, who;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] rq;

    m_reset();
    #1 reset_n = 1'b0;
    step('0, 4'd0);
    reset_n = 1'b1;
    step('0, 4'd0);
    chk("idle_grant", 32'(grant), 32'd0);

    // Single request latency and capture
    step(4'b0001, 4'd7);
    chk("single_grant", 32'(grant), 32'd1);
    run_until_ack(4'b0001, 4'd7, n, who);
    chk("single_latency", 32'(n + 1), 32'(W + 2));
    chk("single_value", 32'(draw_value), 32'd7);
    chk("single_who", 32'(who), 32'd0);
    step('0, 4'd0);

    // Fairness with all four held
    arst();
    for (int i = 0; i < 5; i++) begin
      run_until_ack(4'b1111, 4'd3, n, who);
      chk("fair_order", 32'(who), 32'(order[i]));
    end
    step('0, 4'd0);
    step('0, 4'd0);

    // Out-of-range retries in SAMPLE
    for (int i = 0; i < W + 1; i++) step(4'b0001, 4'd12);
    step(4'b0001, 4'd12);
    chk("oor_retry1", 32'(ack), 32'd0);
    step(4'b0001, 4'd13);
    chk("oor_retry2", 32'(ack), 32'd0);
    step(4'b0001, 4'd5);
    chk("oor_ack", 32'(ack), 32'd1);
    chk("oor_value", 32'(draw_value), 32'd5);
    step('0, 4'd0);
    step('0, 4'd0);

    // Abort in SETTLE keeps pointer and value
    step(4'b0100, 4'd3);
    chk("abort_grant", 32'(grant), 32'd4);
    step(4'b0100, 4'd3);
    step(4'b0000, 4'd3);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_value", 32'(draw_value), 32'd5);
    step(4'b0110, 4'd3);
    chk("abort_next_grant", 32'(grant), 32'd2);
    step('0, 4'd0);

    // Reset while stuck in SAMPLE
    for (int i = 0; i < W + 3; i++) step(4'b0001, 4'd15);
    chk("stuck_busy", 32'(busy), 32'd1);
    arst();
    step(4'b1001, 4'd4);
    chk("post_rst_grant", 32'(grant), 32'd1);
    step('0, 4'd0);

    // MAX_VAL boundary
    for (int i = 0; i < W + 1; i++) step(4'b0001, 4'd11);
    step(4'b0001, 4'd11);
    chk("bound_11_retry", 32'(ack), 32'd0);
    step(4'b0001, 4'd10);
    chk("bound_10_ack", 32'(draw_valid), 32'd1);
    chk("bound_10_value", 32'(draw_value), 32'd10);
    step('0, 4'd0);

    // Random traffic: held requests, occasional aborts, re-requests after ack
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (rq[i] && m_ack && m_ack_who == i) rq[i] = 1'($urandom_range(0, 1));
        else if (rq[i]) rq[i] = ($urandom_range(0, 39) != 0);
        else rq[i] = ($urandom_range(0, 3) == 0);
      end
      step(rq, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
